psum_adder_sched: RTL and testbench

PSUM_ADDER_SCHED -- requirements
Module: psum_adder_sched

---
 rtl/psum_sched_pkg.sv | 26 ++
 rtl/psum_adder_sched_if.sv | 34 +++
 rtl/psum_adder_sched_rr_arbiter.sv | 29 ++
 rtl/psum_adder_sched.sv | 118 +++++++++++
 tb/tb_psum_adder_sched.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/psum_sched_pkg.sv
// Shared types and default sizing for the Psum adder scheduler.
package psum_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } sched_state_e;

    localparam int DEF_NREQ   = 3;
    localparam int DEF_PWIDTH = 47;
    localparam int DEF_NOUT   = 25;
    localparam int DEF_IDXW   = 5;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // (ptr + offset) mod n, assuming both operands are already below n.
    function automatic int rr_index(input int ptr, input int offset, input int n);
        int s;
        s = ptr + offset;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/psum_adder_sched_if.sv
// Bundle of requester, adder and completion signals around the scheduler.
interface psum_adder_sched_if
    import psum_sched_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int PWIDTH = DEF_PWIDTH,
    parameter int IDXW   = DEF_IDXW
);
    localparam int GW = id_width(NREQ);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*PWIDTH-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   add_valid;
    logic [PWIDTH-1:0]      add_data;
    logic                   add_ready;
    logic [GW-1:0]          grant_id;
    logic                   done_valid;
    logic [IDXW-1:0]        done_idx;
    logic                   busy;

    // Scheduler side.
    modport slave (
        input  req_valid, req_data, add_ready,
        output req_ready, add_valid, add_data, grant_id, done_valid, done_idx, busy
    );

    // Requesters plus adder side.
    modport master (
        output req_valid, req_data, add_ready,
        input  req_ready, add_valid, add_data, grant_id, done_valid, done_idx, busy
    );

endinterface

// File: rtl/psum_adder_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or above ptr_i, wrapping.
module rr_arbiter
    import psum_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int GW   = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [GW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [GW-1:0]   idx_o,
    output logic            valid_o
);

    // Walk the requesters starting at the pointer; the first hit wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!valid_o && req_i[rr_index(int'(ptr_i), k, NREQ)]) begin
                grant_o[rr_index(int'(ptr_i), k, NREQ)] = 1'b1;
                idx_o   = GW'(rr_index(int'(ptr_i), k, NREQ));
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/psum_adder_sched.sv
// Shares one Psum adder among NREQ PE requesters and flags each completed output pixel.
module psum_adder_sched
    import psum_sched_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int PWIDTH = DEF_PWIDTH,
    parameter int NOUT   = DEF_NOUT,
    parameter int IDXW   = DEF_IDXW
) (
    input logic               clk,
    input logic               rst,
    psum_adder_sched_if.slave bus
);

    localparam int GW = id_width(NREQ);

    sched_state_e      state_q, state_d;
    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]     pass_cnt_q, pass_cnt_d;
    logic [GW-1:0]     grant_id_q, grant_id_d;
    logic [IDXW-1:0]   out_idx_q, out_idx_d;
    logic [IDXW-1:0]   done_idx_q, done_idx_d;
    logic              done_valid_q, done_valid_d;
    logic [PWIDTH-1:0] add_data_q, add_data_d;
    logic [NREQ-1:0]   req_ready;

    logic [NREQ-1:0]   arb_grant;
    logic [GW-1:0]     arb_idx;
    logic              arb_any;

    rr_arbiter #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_arb (
        .req_i   (bus.req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_any)
    );

    // Next state, capture strobe and completion bookkeeping.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        pass_cnt_d   = pass_cnt_q;
        grant_id_d   = grant_id_q;
        out_idx_d    = out_idx_q;
        done_idx_d   = done_idx_q;
        done_valid_d = 1'b0;
        add_data_d   = add_data_q;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                if (arb_any && !rst) begin
                    req_ready  = arb_grant;
                    add_data_d = bus.req_data[arb_idx*PWIDTH +: PWIDTH];
                    grant_id_d = arb_idx;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (bus.add_ready) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_id_q == GW'(NREQ-1)) ? '0 : grant_id_q + 1'b1;
                    if (pass_cnt_q == GW'(NREQ-1)) begin
                        pass_cnt_d   = '0;
                        done_valid_d = 1'b1;
                        done_idx_d   = out_idx_q;
                        out_idx_d    = (out_idx_q == IDXW'(NOUT-1)) ? '0 : out_idx_q + 1'b1;
                    end else begin
                        pass_cnt_d = pass_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset drops any held packet without completing it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and counters, all cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            pass_cnt_q   <= '0;
            grant_id_q   <= '0;
            out_idx_q    <= '0;
            done_idx_q   <= '0;
            done_valid_q <= 1'b0;
            add_data_q   <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            pass_cnt_q   <= pass_cnt_d;
            grant_id_q   <= grant_id_d;
            out_idx_q    <= out_idx_d;
            done_idx_q   <= done_idx_d;
            done_valid_q <= done_valid_d;
            add_data_q   <= add_data_d;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.add_valid  = (state_q == HOLD);
    assign bus.busy       = (state_q == HOLD);
    assign bus.add_data   = add_data_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.done_valid = done_valid_q;
    assign bus.done_idx   = done_idx_q;

endmodule

// File: tb/tb_psum_adder_sched.sv
// Directed self-checking bench for psum_adder_sched with NREQ=3, PWIDTH=47, NOUT=25.
module tb_psum_adder_sched;

    localparam int NREQ   = 3;
    localparam int PWIDTH = 47;
    localparam int NOUT   = 25;
    localparam int IDXW   = 5;

    logic clk;
    logic rst;
    int   nChecks;
    int   nFails;

    psum_adder_sched_if #(.NREQ(NREQ), .PWIDTH(PWIDTH), .IDXW(IDXW)) bus ();

    psum_adder_sched #(
        .NREQ   (NREQ),
        .PWIDTH (PWIDTH),
        .NOUT   (NOUT),
        .IDXW   (IDXW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic ready);
        bus.req_valid = valid;
        bus.add_ready = ready;
        #1;
    endtask

    task automatic applyReset();
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.add_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic loadData(input logic [PWIDTH-1:0] d0, input logic [PWIDTH-1:0] d1,
                            input logic [PWIDTH-1:0] d2);
        bus.req_data = {d2, d1, d0};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        loadData(47'h1, 47'h2, 47'h3);
        bus.req_valid = 3'b111;
        bus.add_ready = 1'b1;
        tick();
        tick();
        nChecks++; if (bus.req_ready !== 3'b000) begin nFails++; $display("[TB] FAIL reset_ready: got %b expected 000", bus.req_ready); end
        nChecks++; if (bus.add_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_add_valid: got %b expected 0", bus.add_valid); end
        nChecks++; if (bus.add_data !== 47'h0) begin nFails++; $display("[TB] FAIL reset_add_data: got %h expected 0", bus.add_data); end
        nChecks++; if (bus.grant_id !== 2'd0) begin nFails++; $display("[TB] FAIL reset_grant_id: got %0d expected 0", bus.grant_id); end
        nChecks++; if (bus.done_valid !== 1'b0 || bus.done_idx !== 5'd0) begin nFails++; $display("[TB] FAIL reset_done: got %b/%0d expected 0/0", bus.done_valid, bus.done_idx); end
        nChecks++; if (bus.busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        bus.req_valid = '0;
        rst = 1'b0;
    endtask

    task automatic test_single();
        applyReset();
        loadData(47'h0, 47'h155, 47'h0);
        applyStimulus(3'b010, 1'b1);
        nChecks++; if (bus.req_ready !== 3'b010) begin nFails++; $display("[TB] FAIL single_ready: got %b expected 010", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        #1;
        nChecks++; if (bus.add_valid !== 1'b1 || bus.add_data !== 47'h155) begin nFails++; $display("[TB] FAIL single_data: got %b/%h expected 1/155", bus.add_valid, bus.add_data); end
        nChecks++; if (bus.grant_id !== 2'd1) begin nFails++; $display("[TB] FAIL single_grant_id: got %0d expected 1", bus.grant_id); end
        nChecks++; if (bus.req_ready !== 3'b000) begin nFails++; $display("[TB] FAIL single_hold_ready: got %b expected 000", bus.req_ready); end
        tick();
        nChecks++; if (bus.add_valid !== 1'b0) begin nFails++; $display("[TB] FAIL single_release: got %b expected 0", bus.add_valid); end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] expReady;
        applyReset();
        loadData(47'h100, 47'h101, 47'h102);
        applyStimulus(3'b111, 1'b1);
        for (int t = 0; t < 6; t++) begin
            expReady = 3'b001 << (t % 3);
            nChecks++; if (bus.req_ready !== expReady) begin nFails++; $display("[TB] FAIL rr_ready[%0d]: got %b expected %b", t, bus.req_ready, expReady); end
            nChecks++; if (bus.done_valid !== (t == 3)) begin nFails++; $display("[TB] FAIL rr_done[%0d]: got %b expected %b", t, bus.done_valid, (t == 3)); end
            if (t == 3) begin
                nChecks++; if (bus.done_idx !== 5'd0) begin nFails++; $display("[TB] FAIL rr_done_idx[%0d]: got %0d expected 0", t, bus.done_idx); end
            end
            tick();
            nChecks++; if (bus.grant_id !== 2'(t % 3) || bus.add_data !== 47'(47'h100 + t % 3)) begin nFails++; $display("[TB] FAIL rr_grant[%0d]: got %0d/%h expected %0d/%h", t, bus.grant_id, bus.add_data, t % 3, 47'h100 + t % 3); end
            tick();
        end
        nChecks++; if (bus.done_valid !== 1'b1 || bus.done_idx !== 5'd1) begin nFails++; $display("[TB] FAIL rr_done_final: got %b/%0d expected 1/1", bus.done_valid, bus.done_idx); end
        bus.req_valid = '0;
    endtask

    task automatic test_stall();
        applyReset();
        loadData(47'hABC, 47'h0, 47'h777);
        applyStimulus(3'b001, 1'b0);
        tick();
        bus.req_valid = 3'b100;
        #1;
        for (int c = 0; c < 5; c++) begin
            nChecks++; if (bus.add_valid !== 1'b1 || bus.add_data !== 47'hABC || bus.busy !== 1'b1) begin nFails++; $display("[TB] FAIL stall_hold[%0d]: got %b/%h/%b expected 1/abc/1", c, bus.add_valid, bus.add_data, bus.busy); end
            nChecks++; if (bus.req_ready !== 3'b000) begin nFails++; $display("[TB] FAIL stall_ready[%0d]: got %b expected 000", c, bus.req_ready); end
            tick();
        end
        bus.add_ready = 1'b1;
        #1;
        nChecks++; if (bus.add_valid !== 1'b1 || bus.add_data !== 47'hABC) begin nFails++; $display("[TB] FAIL stall_sixth: got %b/%h expected 1/abc", bus.add_valid, bus.add_data); end
        tick();
        nChecks++; if (bus.add_valid !== 1'b0 || bus.busy !== 1'b0) begin nFails++; $display("[TB] FAIL stall_done: got %b/%b expected 0/0", bus.add_valid, bus.busy); end
        nChecks++; if (bus.req_ready !== 3'b100) begin nFails++; $display("[TB] FAIL stall_next_ready: got %b expected 100", bus.req_ready); end
        bus.req_valid = '0;
    endtask

    task automatic test_done_wrap();
        int   doneCount;
        logic expDone;
        doneCount = 0;
        applyReset();
        loadData(47'h10, 47'h20, 47'h30);
        applyStimulus(3'b111, 1'b1);
        for (int n = 0; n <= 78; n++) begin
            expDone = (n > 0) && (n % 3 == 0);
            if (bus.done_valid === 1'b1) doneCount++;
            nChecks++; if (bus.done_valid !== expDone) begin nFails++; $display("[TB] FAIL wrap_done[%0d]: got %b expected %b", n, bus.done_valid, expDone); end
            if (expDone) begin
                nChecks++; if (bus.done_idx !== 5'((n / 3 - 1) % NOUT)) begin nFails++; $display("[TB] FAIL wrap_idx[%0d]: got %0d expected %0d", n, bus.done_idx, (n / 3 - 1) % NOUT); end
            end
            if (n < 78) begin
                tick();
                if (bus.done_valid === 1'b1) doneCount++;
                nChecks++; if (bus.done_valid !== 1'b0 || bus.grant_id !== 2'(n % 3)) begin nFails++; $display("[TB] FAIL wrap_hold[%0d]: got %b/%0d expected 0/%0d", n, bus.done_valid, bus.grant_id, n % 3); end
                tick();
            end
        end
        nChecks++; if (doneCount != 26) begin nFails++; $display("[TB] FAIL wrap_count: got %0d expected 26", doneCount); end
        bus.req_valid = '0;
    endtask

    task automatic test_reset_in_hold();
        applyReset();
        loadData(47'h5, 47'h6, 47'h7);
        applyStimulus(3'b111, 1'b1);
        for (int t = 0; t < 2; t++) begin
            tick();
            tick();
        end
        tick();
        nChecks++; if (bus.grant_id !== 2'd2 || bus.add_valid !== 1'b1) begin nFails++; $display("[TB] FAIL rsthold_pre: got %0d/%b expected 2/1", bus.grant_id, bus.add_valid); end
        rst = 1'b1;
        tick();
        nChecks++; if (bus.add_valid !== 1'b0 || bus.busy !== 1'b0) begin nFails++; $display("[TB] FAIL rsthold_flush: got %b/%b expected 0/0", bus.add_valid, bus.busy); end
        nChecks++; if (bus.done_valid !== 1'b0) begin nFails++; $display("[TB] FAIL rsthold_no_done: got %b expected 0", bus.done_valid); end
        nChecks++; if (bus.req_ready !== 3'b000) begin nFails++; $display("[TB] FAIL rsthold_ready_in_rst: got %b expected 000", bus.req_ready); end
        rst = 1'b0;
        #1;
        nChecks++; if (bus.req_ready !== 3'b001) begin nFails++; $display("[TB] FAIL rsthold_first_grant: got %b expected 001", bus.req_ready); end
        for (int t = 0; t < 3; t++) begin
            tick();
            tick();
            nChecks++; if (bus.done_valid !== (t == 2)) begin nFails++; $display("[TB] FAIL rsthold_pass[%0d]: got %b expected %b", t, bus.done_valid, (t == 2)); end
        end
        nChecks++; if (bus.done_idx !== 5'd0) begin nFails++; $display("[TB] FAIL rsthold_idx: got %0d expected 0", bus.done_idx); end
        bus.req_valid = '0;
    endtask

    task automatic test_rr_skip();
        applyReset();
        loadData(47'hA0, 47'hA1, 47'hA2);
        applyStimulus(3'b001, 1'b1);
        tick();
        bus.req_valid = 3'b000;
        tick();
        applyStimulus(3'b101, 1'b1);
        nChecks++; if (bus.req_ready !== 3'b100) begin nFails++; $display("[TB] FAIL skip_first: got %b expected 100", bus.req_ready); end
        tick();
        nChecks++; if (bus.grant_id !== 2'd2 || bus.add_data !== 47'hA2) begin nFails++; $display("[TB] FAIL skip_first_hold: got %0d/%h expected 2/a2", bus.grant_id, bus.add_data); end
        tick();
        nChecks++; if (bus.req_ready !== 3'b001) begin nFails++; $display("[TB] FAIL skip_second: got %b expected 001", bus.req_ready); end
        tick();
        nChecks++; if (bus.grant_id !== 2'd0 || bus.add_data !== 47'hA0) begin nFails++; $display("[TB] FAIL skip_second_hold: got %0d/%h expected 0/a0", bus.grant_id, bus.add_data); end
        bus.req_valid = '0;
    endtask

    // Runs each scenario in turn, then reports the totals.
    initial begin
        nChecks       = 0;
        nFails        = 0;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.add_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_done_wrap();
        test_reset_in_hold();
        test_rr_skip();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
